// File: rtl/mem_pkg.sv
// Shared definitions for the block memory and the cache controller that drives it.
//   DEFAULT_LATENCY : clock edges from request acceptance to completion
//   DEFAULT_ADDR_W  : block address width ({tag, index})
//   DEFAULT_DATA_W  : block width in bits (four bytes, byte 0 in [7:0])
//   CNT_W           : width of the latency counter (covers LATENCY up to 15)
//   mem_state_e     : request state machine states
//   mem_op_e        : captured operation type
package mem_pkg;

  localparam int DEFAULT_LATENCY = 5;
  localparam int DEFAULT_ADDR_W  = 6;
  localparam int DEFAULT_DATA_W  = 32;
  localparam int CNT_W           = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } mem_op_e;

endpackage

// File: rtl/mem_latency_counter.sv
// Loadable down-counter used to time a memory request.
// Ports:
//   clock      : rising-edge clock
//   reset      : asynchronous, active-high reset (count -> 0)
//   load       : load load_value this edge (has priority over enable)
//   enable     : decrement by one per edge while non-zero
//   load_value : value loaded on load
//   done       : high while the count is zero
module mem_latency_counter #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic         enable,
  input  logic [W-1:0] load_value,
  output logic         done
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (enable && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/block_memory.sv
// Fixed-latency block memory serving one cache-controller request at a time.
// A request (read xor write) seen in IDLE is captured at that edge (E0); the
// operation completes at E0+LATENCY, then one DONE cycle precedes IDLE again.
// Ports:
//   clock     : rising-edge system clock
//   reset     : asynchronous, active-high reset (clears state, array, readdata)
//   read      : block read request
//   write     : block write-back request
//   address   : block address {tag, index}
//   writedata : block to store
//   readdata  : block returned by the last completed read
//   busywait  : high while a request is pending or in service
module block_memory
  import mem_pkg::*;
#(
  parameter int LATENCY = DEFAULT_LATENCY,
  parameter int ADDR_W  = DEFAULT_ADDR_W,
  parameter int DATA_W  = DEFAULT_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  output logic              busywait
);

  localparam int DEPTH = 1 << ADDR_W;

  mem_state_e        state_q, state_d;
  mem_op_e           op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] readdata_q, readdata_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  logic accept;
  logic complete;
  logic commit;
  logic cnt_done;

  // Loaded with LATENCY-1 at E0 so it reaches zero just before edge E0+LATENCY.
  mem_latency_counter #(
    .W(CNT_W)
  ) u_counter (
    .clock      (clock),
    .reset      (reset),
    .load       (accept),
    .enable     (state_q == ST_BUSY),
    .load_value (CNT_W'(LATENCY - 1)),
    .done       (cnt_done)
  );

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    complete = 1'b0;
    busywait = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // read&write together is not a legal request and is ignored.
        if (read ^ write) begin
          busywait = 1'b1;
          accept   = 1'b1;
          state_d  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        busywait = 1'b1;
        if (cnt_done) begin
          complete = 1'b1;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Request fields are frozen at E0; later input changes have no effect.
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    op_d    = op_q;
    if (accept) begin
      addr_d  = address;
      wdata_d = writedata;
      op_d    = write ? OP_WRITE : OP_READ;
    end
  end

  assign commit = complete && (op_q == OP_WRITE);

  always_comb begin
    readdata_d = readdata_q;
    if (complete && (op_q == OP_READ)) begin
      readdata_d = mem_q[addr_q];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_READ;
      addr_q     <= '0;
      wdata_q    <= '0;
      readdata_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      readdata_q <= readdata_d;
    end
  end

  // Storage lives in resettable flops so the whole array clears on reset.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_comb begin
      mem_d[gi] = mem_q[gi];
      if (commit && (addr_q == ADDR_W'(gi))) begin
        mem_d[gi] = wdata_q;
      end
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        mem_q[gi] <= '0;
      end else begin
        mem_q[gi] <= mem_d[gi];
      end
    end
  end

  assign readdata = readdata_q;

endmodule
